// File: rtl/alu_sequencer.sv
// Command front-end for the 16-bit combinational ALU.
// It holds the register file, registers the ALU operands and returns each result over valid/ready.
module alu_sequencer #(
  parameter int unsigned W     = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned RW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_load,
  input  logic          cmd_mode,
  input  logic [3:0]    cmd_select,
  input  logic          cmd_use_carry,
  input  logic [RW-1:0] cmd_rd,
  input  logic [RW-1:0] cmd_ra,
  input  logic [RW-1:0] cmd_rb,
  input  logic [W-1:0]  cmd_imm,
  output logic [W-1:0]  alu_in_a,
  output logic [W-1:0]  alu_in_b,
  output logic [3:0]    alu_select,
  output logic          alu_mode,
  output logic          alu_carry_in,
  input  logic [W-1:0]  alu_result,
  input  logic          alu_carry_out,
  input  logic          alu_compare,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          rsp_carry,
  output logic          rsp_zero,
  output logic          rsp_compare
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e        state_q;
  logic [W-1:0]  regs_q [NREGS];
  logic [RW-1:0] rd_q;
  logic          carry_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      rd_q         <= '0;
      carry_q      <= 1'b0;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_select   <= '0;
      alu_mode     <= 1'b0;
      alu_carry_in <= 1'b0;
      rsp_data     <= '0;
      rsp_compare  <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_load) begin
              regs_q[cmd_rd] <= cmd_imm;
              rsp_data       <= cmd_imm;
              rsp_compare    <= 1'b0;
              state_q        <= StResp;
            end else begin
              // Operands are sampled here, so ra/rb may alias rd safely.
              alu_in_a     <= regs_q[cmd_ra];
              alu_in_b     <= regs_q[cmd_rb];
              alu_select   <= cmd_select;
              alu_mode     <= cmd_mode;
              alu_carry_in <= cmd_use_carry & carry_q;
              rd_q         <= cmd_rd;
              state_q      <= StExec;
            end
          end
        end
        StExec: begin
          regs_q[rd_q] <= alu_result;
          rsp_data     <= alu_result;
          carry_q      <= alu_carry_out;
          rsp_compare  <= alu_compare;
          state_q      <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  // Flags are qualified by rsp_valid so they read 0 out of reset.
  assign rsp_zero  = rsp_valid && (rsp_data == '0);
  assign rsp_carry = rsp_valid && carry_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU model as the responder.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_load = 1'b0;
  logic        cmd_mode = 1'b0;
  logic [3:0]  cmd_select = '0;
  logic        cmd_use_carry = 1'b0;
  logic [2:0]  cmd_rd = '0;
  logic [2:0]  cmd_ra = '0;
  logic [2:0]  cmd_rb = '0;
  logic [15:0] cmd_imm = '0;
  logic [15:0] alu_in_a;
  logic [15:0] alu_in_b;
  logic [3:0]  alu_select;
  logic        alu_mode;
  logic        alu_carry_in;
  logic [15:0] alu_result;
  logic        alu_carry_out;
  logic        alu_compare;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_compare;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.W(16), .NREGS(8), .RW(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_load      (cmd_load),
    .cmd_mode      (cmd_mode),
    .cmd_select    (cmd_select),
    .cmd_use_carry (cmd_use_carry),
    .cmd_rd        (cmd_rd),
    .cmd_ra        (cmd_ra),
    .cmd_rb        (cmd_rb),
    .cmd_imm       (cmd_imm),
    .alu_in_a      (alu_in_a),
    .alu_in_b      (alu_in_b),
    .alu_select    (alu_select),
    .alu_mode      (alu_mode),
    .alu_carry_in  (alu_carry_in),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out),
    .alu_compare   (alu_compare),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_carry     (rsp_carry),
    .rsp_zero      (rsp_zero),
    .rsp_compare   (rsp_compare)
  );

  always #5 clk = ~clk;

  // Subset of the 74181-style ALU used by the directed steps below.
  logic [16:0] sum;
  always_comb begin
    sum           = '0;
    alu_result    = '0;
    alu_carry_out = 1'b0;
    alu_compare   = (alu_in_a == alu_in_b);
    if (alu_mode) begin
      case (alu_select)
        4'b0011: alu_result = 16'h0000;
        4'b0110: alu_result = alu_in_a ^ alu_in_b;
        4'b1011: alu_result = alu_in_a & alu_in_b;
        4'b1110: alu_result = alu_in_a | alu_in_b;
        4'b1111: alu_result = alu_in_a;
        default: alu_result = ~alu_in_a;
      endcase
    end else begin
      case (alu_select)
        4'b1001: sum = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {16'h0, alu_carry_in};
        default: sum = {1'b0, alu_in_a} + {16'h0, alu_carry_in};
      endcase
      alu_result    = sum[15:0];
      alu_carry_out = sum[16];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one command for a single accept edge; caller must be in IDLE.
  task automatic issue(input logic ld, input logic md, input logic [3:0] sel, input logic uc,
                       input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [15:0] imm);
    cmd_load      = ld;
    cmd_mode      = md;
    cmd_select    = sel;
    cmd_use_carry = uc;
    cmd_rd        = rd;
    cmd_ra        = ra;
    cmd_rb        = rb;
    cmd_imm       = imm;
    cmd_valid     = 1'b1;
    tick();
    cmd_valid     = 1'b0;
  endtask

  // ALU op with rsp_ready high: checks EXEC then RESP, then returns to IDLE.
  task automatic alu_op(input string tag, input logic md, input logic [3:0] sel, input logic uc,
                        input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                        input logic [15:0] exp_a, input logic exp_cin,
                        input logic [15:0] exp_data, input logic exp_carry,
                        input logic exp_cmp);
    issue(1'b0, md, sel, uc, rd, ra, rb, 16'h0);
    check({tag, " exec rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, " exec cmd_ready"}, {31'h0, cmd_ready}, 32'h0);
    check({tag, " alu_in_a"}, {16'h0, alu_in_a}, {16'h0, exp_a});
    check({tag, " alu_select"}, {27'h0, alu_mode, alu_select}, {27'h0, md, sel});
    check({tag, " alu_carry_in"}, {31'h0, alu_carry_in}, {31'h0, exp_cin});
    tick();
    check({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, " rsp_data"}, {16'h0, rsp_data}, {16'h0, exp_data});
    check({tag, " rsp_carry"}, {31'h0, rsp_carry}, {31'h0, exp_carry});
    check({tag, " rsp_zero"}, {31'h0, rsp_zero}, {31'h0, (exp_data == 16'h0)});
    check({tag, " rsp_compare"}, {31'h0, rsp_compare}, {31'h0, exp_cmp});
    tick();
    check({tag, " back to idle"}, {30'h0, rsp_valid, cmd_ready}, 32'h1);
  endtask

  task automatic load(input string tag, input logic [2:0] rd, input logic [15:0] imm,
                      input logic exp_carry);
    issue(1'b1, 1'b0, 4'h0, 1'b0, rd, 3'd0, 3'd0, imm);
    check({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, " rsp_data"}, {16'h0, rsp_data}, {16'h0, imm});
    check({tag, " rsp_compare"}, {31'h0, rsp_compare}, 32'h0);
    check({tag, " rsp_carry"}, {31'h0, rsp_carry}, {31'h0, exp_carry});
    tick();
    check({tag, " back to idle"}, {30'h0, rsp_valid, cmd_ready}, 32'h1);
  endtask

  logic [15:0] held_data;

  initial begin
    #3;
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset rsp_data", {16'h0, rsp_data}, 32'h0);
    check("reset rsp_flags", {29'h0, rsp_carry, rsp_zero, rsp_compare}, 32'h0);
    check("reset alu_ab", {alu_in_a, alu_in_b}, 32'h0);
    check("reset alu_ctl", {26'h0, alu_select, alu_mode, alu_carry_in}, 32'h0);
    #10 rst = 1'b1;
    tick();
    check("post-reset cmd_ready", {31'h0, cmd_ready}, 32'h1);

    load("ld r1", 3'd1, 16'h1234, 1'b0);
    load("ld r2", 3'd2, 16'h0001, 1'b0);

    alu_op("add r3", 1'b0, 4'b1001, 1'b0, 3'd3, 3'd1, 3'd2, 16'h1234, 1'b0, 16'h1235, 1'b0, 1'b0);
    check("add r3 alu_in_b kept", {16'h0, alu_in_b}, 32'h0001);
    // Reads r3 written just before; use_carry with flag 0 must drive 0.
    alu_op("pass r3", 1'b0, 4'b0000, 1'b1, 3'd5, 3'd3, 3'd3, 16'h1235, 1'b0, 16'h1235, 1'b0, 1'b1);
    alu_op("zero r4", 1'b1, 4'b0011, 1'b0, 3'd4, 3'd1, 3'd2, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
    alu_op("xor r1r1", 1'b1, 4'b0110, 1'b0, 3'd6, 3'd1, 3'd1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1);

    load("ld r7", 3'd7, 16'hFFFF, 1'b0);
    alu_op("wrap", 1'b0, 4'b1001, 1'b0, 3'd6, 3'd7, 3'd2, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    load("ld keeps carry", 3'd5, 16'h00AA, 1'b1);
    alu_op("nouse carry", 1'b0, 4'b1001, 1'b0, 3'd0, 3'd1, 3'd2, 16'h1234, 1'b0, 16'h1235, 1'b0,
           1'b0);
    alu_op("wrap2", 1'b0, 4'b1001, 1'b0, 3'd6, 3'd7, 3'd2, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    alu_op("use carry", 1'b0, 4'b1001, 1'b1, 3'd0, 3'd1, 3'd2, 16'h1234, 1'b1, 16'h1236, 1'b0,
           1'b0);

    // Backpressure: response held while a load waits at the command port.
    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 4'b1001, 1'b0, 3'd3, 3'd1, 3'd1, 16'h0);
    tick();
    held_data = 16'h2468;
    cmd_load  = 1'b1;
    cmd_rd    = 3'd5;
    cmd_imm   = 16'hBEEF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp rsp_data", {16'h0, rsp_data}, {16'h0, held_data});
      check("bp cmd_ready", {31'h0, cmd_ready}, 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp handshake idle", {30'h0, rsp_valid, cmd_ready}, 32'h1);
    tick();
    cmd_valid = 1'b0;
    check("bp pending load", {15'h0, rsp_valid, rsp_data}, {15'h0, 1'b1, 16'hBEEF});
    tick();

    // Reset mid-EXEC discards the op bound for r1.
    issue(1'b0, 1'b0, 4'b1001, 1'b0, 3'd1, 3'd2, 3'd2, 16'h0);
    check("pre-rst in exec", {16'h0, alu_in_a}, 32'h0001);
    #2 rst = 1'b0;
    #1;
    check("rst alu_ab", {alu_in_a, alu_in_b}, 32'h0);
    check("rst alu_ctl", {26'h0, alu_select, alu_mode, alu_carry_in}, 32'h0);
    check("rst rsp", {13'h0, rsp_valid, rsp_carry, rsp_zero, rsp_data}, 32'h0);
    tick();
    tick();
    check("rst held rsp_valid", {31'h0, rsp_valid}, 32'h0);
    rst = 1'b1;
    tick();
    check("rst release cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst release rsp_valid", {31'h0, rsp_valid}, 32'h0);
    alu_op("read r1", 1'b1, 4'b1111, 1'b0, 3'd0, 3'd1, 3'd1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    alu_op("read r3", 1'b1, 4'b1111, 1'b0, 3'd0, 3'd3, 3'd1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
